tt_out_sig_monitor: RTL and testbench

On-chip response compactor for the Tiny Tapeout user-project pin interface. It observes the project's outputs (`uo_out`, plus `uio_out` gated by `uio_oe`) over a programmed window of clock cycles. It folds every sample into a 16-bit MISR signature, so a cocotb bench or silicon bring-up host checks one word instead of a per-cycle trace. It sits beside the user project in `tb` and in the test harness; it is the capture end of the pin interface that the bench drives through `ui_in`/`uio_in`.

---
 rtl/tt_out_sig_monitor_pkg.sv | 23 ++
 rtl/tt_out_sig_monitor_if.sv | 39 +++
 rtl/tt_out_sig_monitor_misr16.sv | 39 +++
 rtl/tt_out_sig_monitor.sv | 104 ++++++++++
 tb/tb_tt_out_sig_monitor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_out_sig_monitor_pkg.sv
// Shared types, constants and MISR step for the output signature monitor.
// The optional pass/expected check is enabled by SIG_MONITOR_CHECK_EN.
package tt_sig_pkg;
    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] DEF_SEED = 16'hFFFF;
    localparam logic [SIG_W-1:0] DEF_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sig_state_t;

    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] d,
        input logic [SIG_W-1:0] poly
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? poly : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ d;
    endfunction
endpackage

// File: rtl/tt_out_sig_monitor_if.sv
// Pin-observation and control bundle for tt_out_sig_monitor.
// expected/pass exist only when SIG_MONITOR_CHECK_EN is defined.
interface tt_out_sig_monitor_if #(
    parameter int LEN_W = 16
);
    import tt_sig_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       uo_out;
    logic [7:0]       uio_out;
    logic [7:0]       uio_oe;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [LEN_W-1:0] count;
`ifdef SIG_MONITOR_CHECK_EN
    logic [SIG_W-1:0] expected;
    logic             pass;

    modport master (
        output start, len, uo_out, uio_out, uio_oe, expected,
        input  busy, done, signature, count, pass
    );
    modport slave (
        input  start, len, uo_out, uio_out, uio_oe, expected,
        output busy, done, signature, count, pass
    );
`else
    modport master (
        output start, len, uo_out, uio_out, uio_oe,
        input  busy, done, signature, count
    );
    modport slave (
        input  start, len, uo_out, uio_out, uio_oe,
        output busy, done, signature, count
    );
`endif
endinterface

// File: rtl/tt_out_sig_monitor_misr16.sv
// 16-bit MISR register with seed load and step enable.
// o_next exposes the value the register takes at the next edge.
import tt_sig_pkg::*;

module tt_misr16 #(
    parameter logic [SIG_W-1:0] SEED = DEF_SEED,
    parameter logic [SIG_W-1:0] POLY = DEF_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_d,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_next
);
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    always_comb begin
        w_next = r_sig;
        if (i_load) begin
            w_next = SEED;
        end else if (i_en) begin
            w_next = misr_step(r_sig, i_d, POLY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else begin
            r_sig <= w_next;
        end
    end

    assign o_sig  = r_sig;
    assign o_next = w_next;
endmodule

// File: rtl/tt_out_sig_monitor.sv
// Capture-window controller folding project outputs into a MISR signature.
// Define SIG_MONITOR_CHECK_EN to add the expected/pass comparison.
import tt_sig_pkg::*;

module tt_out_sig_monitor #(
    parameter int               LEN_W = 16,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
    input logic            clk,
    input logic            rst,
    tt_out_sig_monitor_if.slave bus
);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    sig_state_t       r_state;
    sig_state_t       w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [SIG_W-1:0] w_d;
    logic [SIG_W-1:0] w_sig;
    logic [SIG_W-1:0] w_sig_next;

    assign w_accept = bus.start && (r_state != RUN);
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_count == (r_len - ONE));
    // Bidirectional pins not driven by the project fold in as zero.
    assign w_d      = {bus.uio_out & bus.uio_oe, bus.uo_out};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next = (bus.len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len   <= bus.len;
                r_count <= '0;
            end else if (w_run) begin
                r_count <= r_count + ONE;
            end
        end
    end

    tt_misr16 #(
        .SEED (SEED),
        .POLY (POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_en   (w_run),
        .i_d    (w_d),
        .o_sig  (w_sig),
        .o_next (w_sig_next)
    );

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.signature = w_sig;
    assign bus.count     = r_count;

`ifdef SIG_MONITOR_CHECK_EN
    logic [SIG_W-1:0] r_expected;
    logic [SIG_W-1:0] w_exp_next;
    logic             r_pass;

    assign w_exp_next = w_accept ? bus.expected : r_expected;

    // Compare against next-edge values so pass is valid as done rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_expected <= w_exp_next;
            r_pass     <= (w_next == DONE) && (w_sig_next == w_exp_next);
        end
    end

    assign bus.pass = r_pass;
`endif
endmodule

// File: tb/tb_tt_out_sig_monitor.sv
// Randomized scoreboard bench for tt_out_sig_monitor.
// Exercises the expected/pass path when SIG_MONITOR_CHECK_EN is defined.
module tb_tt_out_sig_monitor;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    bit   prev_done;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
        bit          pass;
        int          cyc;
    } exp_t;

    exp_t q[$];

    tt_out_sig_monitor_if #(.LEN_W(16)) bus ();

    tt_out_sig_monitor #(
        .LEN_W (16),
        .SEED  (16'hFFFF),
        .POLY  (16'h1021)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: shift left, xor taps when the dropped bit was set, xor data.
    function automatic logic [15:0] ref_step(input logic [15:0] s,
                                             input logic [15:0] d);
        int v;
        v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h1021;
        return v[15:0] ^ d;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (!rst && bus.done && !prev_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no window");
            end else begin
                x = q.pop_front();
                check("signature", 32'(bus.signature), 32'(x.sig));
                check("count", 32'(bus.count), 32'(x.cnt));
                check("busy_at_done", 32'(bus.busy), 32'(0));
                check("done_cycle", 32'(cyc), 32'(x.cyc));
`ifdef SIG_MONITOR_CHECK_EN
                check("pass", 32'(bus.pass), 32'(x.pass));
`endif
            end
        end
        prev_done = bus.done;
    end

    // pmode: 0 random, 1 zeros, 2 fixed; esel: 0 model, 1 zero, 2 random
    task automatic run_window(input int L, input int pmode, input int esel,
                              input int rst_at, input bit mid);
        logic [7:0]  uo[$];
        logic [7:0]  uio[$];
        logic [7:0]  oe[$];
        logic [15:0] m;
        logic [15:0] e;
        exp_t        x;
        m = 16'hFFFF;
        for (int i = 0; i < L; i++) begin
            case (pmode)
                1: begin uo.push_back(8'h00); uio.push_back(8'h00);
                         oe.push_back(8'h00); end
                2: begin uo.push_back(8'h5A); uio.push_back(8'hFF);
                         oe.push_back(8'h0F); end
                default: begin
                    uo.push_back(8'($urandom));
                    uio.push_back(8'($urandom));
                    oe.push_back(8'($urandom));
                end
            endcase
            m = ref_step(m, {uio[i] & oe[i], uo[i]});
        end
        e = (esel == 0) ? m : (esel == 1) ? 16'h0000 : 16'($urandom);
        bus.start = 1'b1;
        bus.len   = 16'(L);
`ifdef SIG_MONITOR_CHECK_EN
        bus.expected = e;
`endif
        x.sig  = m;
        x.cnt  = 16'(L);
        x.pass = (m == e);
        x.cyc  = cyc + 1 + L;
        if (rst_at < 0) q.push_back(x);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = 16'($urandom);
        if (L == 0) check("busy_len0", 32'(bus.busy), 32'(0));
        for (int i = 0; i < L; i++) begin
            if (i == 0) check("busy_run", 32'(bus.busy), 32'(1));
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(bus.busy), 32'(0));
                check("rst_done", 32'(bus.done), 32'(0));
                check("rst_sig", 32'(bus.signature), 32'hFFFF);
                check("rst_count", 32'(bus.count), 32'(0));
`ifdef SIG_MONITOR_CHECK_EN
                check("rst_pass", 32'(bus.pass), 32'(0));
`endif
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            bus.uo_out  = uo[i];
            bus.uio_out = uio[i];
            bus.uio_oe  = oe[i];
            if (mid && i == L / 2) begin
                bus.start = 1'b1;
                bus.len   = 16'($urandom_range(1, 5));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int t;
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        prev_done   = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.uo_out  = '0;
        bus.uio_out = '0;
        bus.uio_oe  = '0;
`ifdef SIG_MONITOR_CHECK_EN
        bus.expected = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_busy", 32'(bus.busy), 32'(0));
        check("init_done", 32'(bus.done), 32'(0));
        check("init_sig", 32'(bus.signature), 32'hFFFF);
        check("init_count", 32'(bus.count), 32'(0));
`ifdef SIG_MONITOR_CHECK_EN
        check("init_pass", 32'(bus.pass), 32'(0));
`endif
        @(posedge clk); #1;

        run_window(0, 0, 0, -1, 1'b0);
        check("len0_sig", 32'(bus.signature), 32'hFFFF);
        check("len0_done", 32'(bus.done), 32'(1));

        run_window(1, 1, 0, -1, 1'b0);
        check("zero_sig", 32'(bus.signature), 32'hEFDF);
        check("zero_done", 32'(bus.done), 32'(1));

        run_window(1, 1, 1, -1, 1'b0);
        run_window(1, 2, 2, -1, 1'b0);
        check("fixed_sig", 32'(bus.signature), 32'hE085);

        run_window(64, 0, 0, -1, 1'b1);
        run_window(20, 0, 0, 10, 1'b0);
        run_window(20, 0, 0, -1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_window($urandom_range(0, 40), 0, $urandom_range(0, 2),
                       -1, 1'(k % 3 == 0));
            if (k % 4 == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
